// File: rtl/asic_iopoc_pkg.sv
// Shared definitions for the padring power-on-control sequencer.
// Contents: FSM state encoding, default debounce/settle lengths and the
// largest supported segment count.
package asic_iopoc_pkg;

   localparam int unsigned DefDebounce = 4;
   localparam int unsigned DefSettle   = 16;
   localparam int unsigned MaxSegs     = 32;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWaitGood = 3'd1,
      StRelease  = 3'd2,
      StOn       = 3'd3,
      StFault    = 3'd4
   } state_e;

endpackage

// File: rtl/asic_iopoc_debounce.sv
// Supply-good qualifier for one padring segment.
// Ports:
//   clk_i      - core clock
//   nreset_i   - asynchronous active-low reset
//   vddio_ok_i - raw IO-supply-good, asynchronous to clk_i
//   good_o     - high once the synchronized input has been high DEBOUNCE cycles
// A 2-flop synchronizer feeds a saturating run-length counter; a synchronized
// low clears both the counter and good_o in the same cycle.
module asic_iopoc_debounce
   import asic_iopoc_pkg::*;
#(
   parameter int unsigned DEBOUNCE = DefDebounce
) (
   input  logic clk_i,
   input  logic nreset_i,
   input  logic vddio_ok_i,
   output logic good_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);

   logic            sync1_q, sync2_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= vddio_ok_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Gating with sync2_q drops good in the cycle the low arrives, not one later.
   assign good_o = sync2_q && (cnt_q == CntMax);

endmodule

// File: rtl/asic_iopocctl.sv
// Padring power-on-control sequencer.
// Debounces per-segment supply-good inputs and, on a level-sensitive request,
// releases each segment's POC line in order 0..N-1, SETTLE cycles apart, then
// reports done SETTLE cycles after the last release.
// Ports:
//   clk_i      - core clock
//   nreset_i   - asynchronous active-low reset
//   en_i       - power-up request (level)
//   vddio_ok_i - per-segment IO-supply-good, asynchronous
//   poc_o      - per-segment power-on-control, 1 = hold IO safe
//   busy_o     - sequencing in progress
//   done_o     - all segments released and settled
//   fault_o    - sticky supply-loss flag
// Build option ASIC_IOPOC_FAULT_EN: when defined, a supply loss during or after
// release parks the sequencer in a fault state until en_i drops; otherwise the
// sequence restarts from segment 0 once supplies are good again.
module asic_iopocctl
   import asic_iopoc_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned DEBOUNCE = DefDebounce,
   parameter int unsigned SETTLE   = DefSettle
) (
   input  logic         clk_i,
   input  logic         nreset_i,
   input  logic         en_i,
   input  logic [N-1:0] vddio_ok_i,
   output logic [N-1:0] poc_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         fault_o
);

   localparam int unsigned SegW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned SetW = $clog2(SETTLE + 1);
   localparam logic [SegW-1:0] LastSeg    = SegW'(N - 1);
   localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE - 1);

   logic [N-1:0] good;

   for (genvar i = 0; i < N; i++) begin : g_deb
      asic_iopoc_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_deb (
         .clk_i      (clk_i),
         .nreset_i   (nreset_i),
         .vddio_ok_i (vddio_ok_i[i]),
         .good_o     (good[i])
      );
   end

   state_e          state_q, state_d;
   logic [SegW-1:0] seg_q, seg_d, seg_next;
   logic [SetW-1:0] settle_q, settle_d;
   logic [N-1:0]    poc_q, poc_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            fault_q, fault_d;

   assign seg_next = seg_q + SegW'(1);

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q  <= StIdle;
         seg_q    <= '0;
         settle_q <= '0;
         poc_q    <= '1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         seg_q    <= seg_d;
         settle_q <= settle_d;
         poc_q    <= poc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      seg_d    = seg_q;
      settle_d = settle_q;
      poc_d    = poc_q;
      busy_d   = busy_q;
      done_d   = done_q;
      fault_d  = fault_q;

      // Dropping the request outranks everything, including a coincident supply loss.
      if (!en_i) begin
         state_d  = StIdle;
         seg_d    = '0;
         settle_d = '0;
         poc_d    = '1;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         fault_d  = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StWaitGood;
               busy_d  = 1'b1;
            end
            StWaitGood: begin
               if (&good) begin
                  state_d  = StRelease;
                  seg_d    = '0;
                  settle_d = '0;
                  poc_d[0] = 1'b0;
               end
            end
            StRelease, StOn: begin
               if (!(&good)) begin
                  poc_d    = '1;
                  done_d   = 1'b0;
                  seg_d    = '0;
                  settle_d = '0;
`ifdef ASIC_IOPOC_FAULT_EN
                  state_d  = StFault;
                  fault_d  = 1'b1;
                  busy_d   = 1'b0;
`else
                  state_d  = StWaitGood;
                  busy_d   = 1'b1;
`endif
               end else if (state_q == StRelease) begin
                  if (settle_q == SettleLast) begin
                     settle_d = '0;
                     if (seg_q == LastSeg) begin
                        state_d = StOn;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end else begin
                        seg_d           = seg_next;
                        poc_d[seg_next] = 1'b0;
                     end
                  end else begin
                     settle_d = settle_q + SetW'(1);
                  end
               end
            end
`ifdef ASIC_IOPOC_FAULT_EN
            StFault: begin
               // Parked with POC asserted until the request is withdrawn.
            end
`endif
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign poc_o  = poc_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
`ifdef ASIC_IOPOC_FAULT_EN
   assign fault_o = fault_q;
`else
   assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_asic_iopocctl.sv
// Bench for asic_iopocctl (N=4, DEBOUNCE=4, SETTLE=16): directed scenarios plus
// randomized traffic, with a per-cycle expectation queue popped by a monitor.
module tb_asic_iopocctl;

   localparam int N = 4;
   localparam int D = 4;
   localparam int S = 16;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         en;
   logic [N-1:0] vddio_ok;
   logic [N-1:0] poc;
   logic         busy, done, fault;

   int checks = 0;
   int errors = 0;

   asic_iopocctl #(
      .N        (N),
      .DEBOUNCE (D),
      .SETTLE   (S)
   ) dut (
      .clk_i      (clk),
      .nreset_i   (nreset),
      .en_i       (en),
      .vddio_ok_i (vddio_ok),
      .poc_o      (poc),
      .busy_o     (busy),
      .done_o     (done),
      .fault_o    (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   // Reference model: supply-good from run lengths of sampled inputs,
   // sequence progress as elapsed cycles since the first release.
   typedef enum {MIdle, MWait, MRun, MFault} mmode_e;
   mmode_e      mode = MIdle;
   int          t = 0;
   int          hi_run[N];
   bit          good_m[N];
   logic [31:0] exp_q[$];

   function automatic logic [31:0] expect_now();
      logic [N-1:0] p;
      logic b, d, f;
      p = '1; b = 1'b0; d = 1'b0; f = 1'b0;
      case (mode)
         MWait:  b = 1'b1;
         MRun: begin
            for (int i = 0; i < N; i++) if (t >= i * S) p[i] = 1'b0;
            d = (t >= N * S);
            b = !d;
         end
         MFault: f = 1'b1;
         default: ;
      endcase
      return 32'({p, b, d, f});
   endfunction

   task automatic model_step();
      bit all_good;
      all_good = 1'b1;
      for (int i = 0; i < N; i++) all_good &= good_m[i];
      if (!en) begin
         mode = MIdle;
      end else begin
         case (mode)
            MIdle: mode = MWait;
            MWait: if (all_good) begin mode = MRun; t = 0; end
            MRun: begin
               if (!all_good) begin
`ifdef ASIC_IOPOC_FAULT_EN
                  mode = MFault;
`else
                  mode = MWait;
`endif
               end else if (t < N * S) begin
                  t++;
               end
            end
            default: ;
         endcase
      end
      // good after this edge needs D+1 consecutive high samples up to the previous edge
      for (int i = 0; i < N; i++) begin
         good_m[i] = (hi_run[i] >= D + 1);
         if (vddio_ok[i] === 1'b1) hi_run[i] = (hi_run[i] < D + 1) ? hi_run[i] + 1 : D + 1;
         else hi_run[i] = 0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge nreset);
         if (!nreset) begin
            mode = MIdle;
            t = 0;
            for (int i = 0; i < N; i++) begin hi_run[i] = 0; good_m[i] = 1'b0; end
         end else begin
            model_step();
         end
         exp_q.delete();
         exp_q.push_back(expect_now());
      end
   end

   // Monitor: outputs are registered, so compare mid-cycle against the queued expectation.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard {poc,busy,done,fault}", 32'({poc, busy, done, fault}), e);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic run_nominal();
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      chk("nominal E busy", 32'(busy), 32'd1);
      chk("nominal E poc", 32'(poc), 32'hF);
      @(posedge clk); #1;
      chk("nominal E+1 poc", 32'(poc), 32'hE);
      repeat (S) @(posedge clk);
      #1 chk("nominal E+17 poc", 32'(poc), 32'hC);
      repeat (S) @(posedge clk);
      #1 chk("nominal E+33 poc", 32'(poc), 32'h8);
      repeat (S) @(posedge clk);
      #1 chk("nominal E+49 poc", 32'(poc), 32'h0);
      chk("nominal E+49 done", 32'(done), 32'd0);
      repeat (S) @(posedge clk);
      #1 chk("nominal E+65 done", 32'(done), 32'd1);
      chk("nominal E+65 busy", 32'(busy), 32'd0);
   endtask

   initial begin
      en = 1'bx;
      vddio_ok = 'x;
      repeat (2) @(negedge clk);
      en = 1'b0;
      vddio_ok = '0;
      repeat (2) @(negedge clk);
      chk("reset poc", 32'(poc), 32'hF);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset fault", 32'(fault), 32'd0);
      nreset = 1'b1;

      // Nominal sequence
      vddio_ok = '1;
      repeat (8) @(negedge clk);
      run_nominal();

      // Supply loss while on
      @(negedge clk);
      vddio_ok[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("loss +2 poc", 32'(poc), 32'h0);
      @(posedge clk); #1;
      chk("loss +3 poc", 32'(poc), 32'hF);
      chk("loss +3 done", 32'(done), 32'd0);
`ifdef ASIC_IOPOC_FAULT_EN
      chk("loss +3 fault", 32'(fault), 32'd1);
      chk("loss +3 busy", 32'(busy), 32'd0);
`else
      chk("loss +3 fault", 32'(fault), 32'd0);
      chk("loss +3 busy", 32'(busy), 32'd1);
`endif
      @(negedge clk);
      vddio_ok[1] = 1'b1;
      repeat (80) @(posedge clk);
`ifdef ASIC_IOPOC_FAULT_EN
      #1 chk("fault held", 32'(fault), 32'd1);
      chk("fault poc", 32'(poc), 32'hF);
`else
      #1 chk("restart done", 32'(done), 32'd1);
      chk("restart poc", 32'(poc), 32'h0);
`endif
      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      chk("en low fault", 32'(fault), 32'd0);
      chk("en low poc", 32'(poc), 32'hF);

      // Debounce: segment 2 never stays high long enough
      @(negedge clk);
      vddio_ok[2] = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int r = 0; r < 10; r++) begin
         vddio_ok[2] = 1'b1;
         repeat (3) @(negedge clk);
         vddio_ok[2] = 1'b0;
         @(negedge clk);
      end
      chk("debounce poc", 32'(poc), 32'hF);
      chk("debounce busy", 32'(busy), 32'd1);
      en = 1'b0;
      vddio_ok[2] = 1'b1;
      repeat (8) @(negedge clk);

      // Abort at E+20, then a full restart
      en = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #1 chk("abort E+20 poc", 32'(poc), 32'hC);
      en = 1'b0;
      @(posedge clk); #1;
      chk("abort E+21 poc", 32'(poc), 32'hF);
      chk("abort E+21 busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      run_nominal();
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);

      // Reset asserted mid-sequence
      en = 1'b1;
      @(posedge clk);
      repeat (30) @(posedge clk);
      #2 nreset = 1'b0;
      #1;
      chk("midreset poc", 32'(poc), 32'hF);
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset done", 32'(done), 32'd0);
      chk("midreset fault", 32'(fault), 32'd0);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      repeat (8) @(negedge clk);
      run_nominal();

      // Randomized traffic
      en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!nreset) begin
            if ($urandom_range(0, 2) == 0) nreset = 1'b1;
         end else if ($urandom_range(0, 1999) == 0) begin
            #1 nreset = 1'b0;
         end
         if ($urandom_range(0, 199) == 0) en = ~en;
         for (int i = 0; i < N; i++) begin
            if (vddio_ok[i]) begin
               if ($urandom_range(0, 599) == 0) vddio_ok[i] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               vddio_ok[i] = 1'b1;
            end
         end
      end
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/asic_iopocctl.md
# asic_iopocctl

Parametrised padring power-on-control sequencer. It generalises the passive POC feed-through cell into an active controller. It watches per-segment IO-supply-good indications, debounces them, and releases the `poc` line of each padring segment in a fixed staggered order so IO drivers leave their safe state one segment at a time. It sits in the always-on core domain next to the padring, and its outputs drive the POC rails of up to N padring segments.

## Interface

**Parameters**
- `N`, 4: number of padring segments (1..32).
- `DEBOUNCE`, 4: consecutive synchronized-high cycles before a segment supply counts as good (1..255).
- `SETTLE`, 16: cycles between successive segment releases, and after the last release before `done` (1..65535).

**Ports**
- `clk`, input, 1: core clock.
- `nreset`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: power-up request, level sensitive.
- `vddio_ok`, input, N: per-segment IO-supply-good; asynchronous to `clk`.
- `poc`, output, N: per-segment power-on-control; 1 holds the segment IO in safe state.
- `busy`, output, 1: sequencing in progress.
- `done`, output, 1: all segments released and settled.
- `fault`, output, 1: supply loss detected; sticky.

## Operation

**Supply-good path:** each `vddio_ok[i]` passes through a 2-flop synchronizer and then a saturating counter of width $clog2(DEBOUNCE+1).
- `good[i]` is 1 once the counter reaches DEBOUNCE.
- A synchronized 0 clears the counter, and `good[i]`, in the same cycle.

**FSM states:** IDLE, WAIT_GOOD, RELEASE, ON, FAULT.
- **IDLE:** all `poc`=1, `busy`=0, `done`=0. Goes to WAIT_GOOD when `en`=1.
- **WAIT_GOOD:** `busy`=1. Goes to RELEASE when all `good` are 1.
- **RELEASE:**
  - An index register `seg` starts at 0. `poc[seg]` clears on entry.
  - A settle counter of width $clog2(SETTLE+1) counts SETTLE cycles. On expiry, `seg` increments and `poc[seg]` clears.
  - After `poc[N-1]` clears plus SETTLE cycles, the FSM goes to ON.
  - Once a segment is released, its `poc` bit stays 0 until a global reassert.
- **ON:** `busy`=0, `done`=1.
- **`en`=0 in any state:** goes to IDLE next cycle, with all `poc`=1 and `done`=0 on that edge.
- **`good[i]`=0 for any i while in RELEASE or ON:** supply-loss event; handling is set by the configuration below.
- **Simultaneous `en` fall and supply loss:** IDLE wins, and `fault` is not set.
- **`nreset` low mid-sequence:** immediate return to the reset values below, regardless of progress.

**Reset values:** `poc`=all 1s, `busy`=0, `done`=0, `fault`=0, FSM=IDLE, `seg`=0, all counters 0.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- `vddio_ok` rising to `good` rising takes 2+DEBOUNCE cycles.
- With all `good`=1 and `en` sampled high at edge E:
  - WAIT_GOOD holds after edge E.
  - `poc[0]`=0 after edge E+1.
  - `poc[i]`=0 after edge E+1+i·SETTLE.
  - `done`=1 after edge E+1+N·SETTLE.
- Supply-loss reaction: the `poc` reassert occurs on the edge after `good` falls, which is 3 cycles after a `vddio_ok` fall.

## Configuration

Controlled by `ASIC_IOPOC_FAULT_EN`.

- **Defined:** supply loss goes to FAULT.
  - All `poc`=1, `fault`=1, `busy`=0, `done`=0.
  - The FSM leaves FAULT only when `en`=0 (to IDLE), which also clears `fault`.
- **Undefined:** supply loss returns to WAIT_GOOD.
  - All `poc`=1, `done`=0, `seg`=0.
  - The sequence restarts automatically; `fault` is tied to 0 and the FAULT state is not built.

## Structure

- **Package `asic_iopoc_pkg`:** FSM state enum (3-bit encoding), default DEBOUNCE/SETTLE constants, and the N upper bound.
- **Sub-module `asic_iopoc_debounce`:** one instance per segment via generate, containing the synchronizer and saturating counter and producing `good`.
- **Top module:** FSM, `seg` index, settle counter, and output registers.

## Test plan

All scenarios use N=4, DEBOUNCE=4, SETTLE=16.

1. **Reset:** `nreset` low, all inputs X then 0 → `poc`=4'hF, `busy`=0, `done`=0, `fault`=0.
2. **Nominal:** `vddio_ok`=4'hF for ≥6 cycles, then `en`=1 at edge E → `poc` is 4'hE at E+1, 4'hC at E+17, 4'h8 at E+33, 4'h0 at E+49; `done`=1 at E+65.
3. **Debounce:** pulse `vddio_ok[2]` high 3 cycles, low 1, repeated, with `en`=1 → stays in WAIT_GOOD, `poc`=4'hF, `busy`=1.
4. **Supply loss in ON:** drop `vddio_ok[1]` →
   - with macro: `poc`=4'hF and `fault`=1 3 cycles later; `fault` clears after `en`=0.
   - without macro: `poc`=4'hF, then the sequence restarts once `vddio_ok[1]` has been high for 6 cycles.
5. **Abort:** `en`=0 at E+20 → `poc`=4'hF, `busy`=0 at E+21; re-raise `en` → full sequence from segment 0.
6. **Mid-sequence reset:** assert `nreset` at E+30 → all outputs return to reset values asynchronously; restart timing matches scenario 2.
